// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad time-entry block: key codes, scanner
// states, the row/column keymap and small decode helpers.
package keypad_pkg;

   localparam logic [3:0] KEY_A      = 4'hA;
   localparam logic [3:0] KEY_B      = 4'hB;
   localparam logic [3:0] KEY_C      = 4'hC;
   localparam logic [3:0] KEY_D      = 4'hD;
   localparam logic [3:0] KEY_STAR   = 4'hE;
   localparam logic [3:0] KEY_HASH   = 4'hF;
   localparam logic [3:0] ROWS_IDLE  = 4'hF;
   localparam logic [3:0] COL_RESET  = 4'b1110;
   localparam logic [2:0] MAX_DIGITS = 3'd4;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HOLD     = 2'd2
   } scan_state_t;

   // Nibble {row,col} holds the code: r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "* 0 # D".
   localparam logic [63:0] KEYMAP_TABLE = 64'hDF0E_C987_B654_A321;

   function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] idx_v;
      idx_v = {row, col};
      return KEYMAP_TABLE[{idx_v, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] col);
      return ~(4'b0001 << col);
   endfunction

   function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
      logic [1:0] row_v;
      if (!rows[0]) begin
         row_v = 2'd0;
      end else if (!rows[1]) begin
         row_v = 2'd1;
      end else if (!rows[2]) begin
         row_v = 2'd2;
      end else begin
         row_v = 2'd3;
      end
      return row_v;
   endfunction

   // HH:MM validity: hour tens 0-2, hour ones 0-3 after a leading 2, minute tens 0-5.
   function automatic logic digit_fits(input logic [2:0] pos, input logic [3:0] digit,
                                       input logic [1:0] hour_tens);
      logic ok_v;
      case (pos)
         3'd0:    ok_v = (digit <= 4'd2);
         3'd1:    ok_v = (hour_tens == 2'd2) ? (digit <= 4'd3) : (digit <= 4'd9);
         3'd2:    ok_v = (digit <= 4'd5);
         3'd3:    ok_v = (digit <= 4'd9);
         default: ok_v = 1'b0;
      endcase
      return ok_v;
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column-scanning keypad reader with press/release debounce and keymap decode.
// Optional KEYPAD_SYNC_EN: rows pass a two-flop synchronizer; SCAN_DIV must then be >= 3.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic       key_strobe,
   output logic [3:0] key_code
);

   localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int MATCH_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(DEBOUNCE_CNT - 1);

   scan_state_t        state_r;
   logic [SLOT_W-1:0]  slot_cnt_r;
   logic [MATCH_W-1:0] match_cnt_r;
   logic [1:0]         col_idx_r;
   logic [3:0]         col_out_r;
   logic [3:0]         pattern_r;
   logic [1:0]         key_row_r;
   logic [1:0]         key_col_r;
   logic               key_strobe_r;
   logic [3:0]         key_code_r;

   logic [3:0]         row_s;
   logic [1:0]         sample_col_s;
   logic               sample_s;
   logic               slot_end_s;

`ifdef KEYPAD_SYNC_EN
   localparam logic [SLOT_W-1:0] SAMPLE_IDX = SLOT_W'(1);
   logic [3:0] row_meta_r;
   logic [3:0] row_sync_r;

   // Two-flop synchronizer on the asynchronous keypad rows.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_meta_r <= ROWS_IDLE;
         row_sync_r <= ROWS_IDLE;
      end else begin
         row_meta_r <= row_in;
         row_sync_r <= row_meta_r;
      end
   end

   // The sample lands two cycles into the next slot, so it belongs to the previous column.
   assign row_s        = row_sync_r;
   assign sample_col_s = col_idx_r - 2'd1;
`else
   localparam logic [SLOT_W-1:0] SAMPLE_IDX = SLOT_LAST;
   assign row_s        = row_in;
   assign sample_col_s = col_idx_r;
`endif

   assign sample_s   = (slot_cnt_r == SAMPLE_IDX);
   assign slot_end_s = (slot_cnt_r == SLOT_LAST);

   assign col_out    = col_out_r;
   assign key_strobe = key_strobe_r;
   assign key_code   = key_code_r;

   // Scan / debounce / hold state machine with registered column drive and key outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_SCAN;
         slot_cnt_r   <= '0;
         match_cnt_r  <= '0;
         col_idx_r    <= 2'd0;
         col_out_r    <= COL_RESET;
         pattern_r    <= ROWS_IDLE;
         key_row_r    <= 2'd0;
         key_col_r    <= 2'd0;
         key_strobe_r <= 1'b0;
         key_code_r   <= 4'd0;
      end else begin
         key_strobe_r <= 1'b0;
         slot_cnt_r   <= slot_end_s ? '0 : slot_cnt_r + SLOT_W'(1);
         case (state_r)
            ST_SCAN: begin
               if (sample_s && (row_s != ROWS_IDLE)) begin
                  state_r     <= ST_DEBOUNCE;
                  pattern_r   <= row_s;
                  key_row_r   <= lowest_low_row(row_s);
                  key_col_r   <= sample_col_s;
                  match_cnt_r <= '0;
                  col_idx_r   <= sample_col_s;
                  col_out_r   <= col_drive(sample_col_s);
               end else if (slot_end_s) begin
                  col_idx_r <= col_idx_r + 2'd1;
                  col_out_r <= col_drive(col_idx_r + 2'd1);
               end
            end
            ST_DEBOUNCE: begin
               if (sample_s) begin
                  if (row_s != pattern_r) begin
                     state_r     <= ST_SCAN;
                     match_cnt_r <= '0;
                  end else if (match_cnt_r == MATCH_LAST) begin
                     state_r      <= ST_HOLD;
                     match_cnt_r  <= '0;
                     key_strobe_r <= 1'b1;
                     key_code_r   <= key_lookup(key_row_r, key_col_r);
                  end else begin
                     match_cnt_r <= match_cnt_r + MATCH_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (sample_s) begin
                  if (row_s == ROWS_IDLE) begin
                     if (match_cnt_r == MATCH_LAST) begin
                        state_r     <= ST_SCAN;
                        match_cnt_r <= '0;
                     end else begin
                        match_cnt_r <= match_cnt_r + MATCH_W'(1);
                     end
                  end else begin
                     match_cnt_r <= '0;
                  end
               end
            end
            default: begin
               state_r     <= ST_SCAN;
               match_cnt_r <= '0;
               col_idx_r   <= 2'd0;
               col_out_r   <= COL_RESET;
            end
         endcase
      end
   end

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad HH:MM entry: scanner front end plus digit validation, edit keys and
// load_time/load_alarm commit pulses. Build option KEYPAD_SYNC_EN lives in the scanner.
module keypad_time_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] col_out,
   input  logic [3:0] row_in,
   output logic       key_strobe,
   output logic [3:0] key_code,
   output logic [3:0] minute_out0,
   output logic [3:0] minute_out1,
   output logic [3:0] hour_out0,
   output logic [1:0] hour_out1,
   output logic [2:0] digit_count,
   output logic       load_time,
   output logic       load_alarm,
   output logic       entry_err
);

   logic       key_strobe_s;
   logic [3:0] key_code_s;
   logic       is_digit_s;
   logic       digit_ok_s;

   logic [1:0] hour_tens_r;
   logic [3:0] hour_ones_r;
   logic [3:0] min_tens_r;
   logic [3:0] min_ones_r;
   logic [2:0] count_r;
   logic       load_time_r;
   logic       load_alarm_r;
   logic       entry_err_r;

   keypad_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) u_scanner (
      .clk        (clk),
      .reset      (reset),
      .row_in     (row_in),
      .col_out    (col_out),
      .key_strobe (key_strobe_s),
      .key_code   (key_code_s)
   );

   assign is_digit_s = (key_code_s <= 4'd9);
   assign digit_ok_s = is_digit_s && (count_r < MAX_DIGITS)
                       && digit_fits(count_r, key_code_s, hour_tens_r);

   assign key_strobe  = key_strobe_s;
   assign key_code    = key_code_s;
   assign hour_out1   = hour_tens_r;
   assign hour_out0   = hour_ones_r;
   assign minute_out1 = min_tens_r;
   assign minute_out0 = min_ones_r;
   assign digit_count = count_r;
   assign load_time   = load_time_r;
   assign load_alarm  = load_alarm_r;
   assign entry_err   = entry_err_r;

   // Apply each strobed key to the entry buffer one cycle after the strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hour_tens_r  <= 2'd0;
         hour_ones_r  <= 4'd0;
         min_tens_r   <= 4'd0;
         min_ones_r   <= 4'd0;
         count_r      <= 3'd0;
         load_time_r  <= 1'b0;
         load_alarm_r <= 1'b0;
         entry_err_r  <= 1'b0;
      end else begin
         load_time_r  <= 1'b0;
         load_alarm_r <= 1'b0;
         entry_err_r  <= 1'b0;
         if (key_strobe_s) begin
            if (is_digit_s) begin
               if (digit_ok_s) begin
                  case (count_r)
                     3'd0:    hour_tens_r <= key_code_s[1:0];
                     3'd1:    hour_ones_r <= key_code_s;
                     3'd2:    min_tens_r  <= key_code_s;
                     3'd3:    min_ones_r  <= key_code_s;
                     default: ;
                  endcase
                  count_r <= count_r + 3'd1;
               end else begin
                  entry_err_r <= 1'b1;
               end
            end else begin
               case (key_code_s)
                  KEY_A: begin
                     if (count_r == MAX_DIGITS) begin
                        load_time_r <= 1'b1;
                        count_r     <= 3'd0;
                     end else begin
                        entry_err_r <= 1'b1;
                     end
                  end
                  KEY_B: begin
                     if (count_r == MAX_DIGITS) begin
                        load_alarm_r <= 1'b1;
                        count_r      <= 3'd0;
                     end else begin
                        entry_err_r <= 1'b1;
                     end
                  end
                  KEY_STAR: begin
                     hour_tens_r <= 2'd0;
                     hour_ones_r <= 4'd0;
                     min_tens_r  <= 4'd0;
                     min_ones_r  <= 4'd0;
                     count_r     <= 3'd0;
                  end
                  KEY_D: begin
                     // Backspace zeroes the most recently entered position.
                     if (count_r != 3'd0) begin
                        case (count_r)
                           3'd1:    hour_tens_r <= 2'd0;
                           3'd2:    hour_ones_r <= 4'd0;
                           3'd3:    min_tens_r  <= 4'd0;
                           3'd4:    min_ones_r  <= 4'd0;
                           default: ;
                        endcase
                        count_r <= count_r - 3'd1;
                     end
                  end
                  KEY_C, KEY_HASH: ;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed bench for keypad_time_entry with SCAN_DIV=4, DEBOUNCE_CNT=2 and a
// behavioural keypad that pulls one row low while its column is driven.
module tb_keypad_time_entry;

   logic       clk;
   logic       reset;
   logic [3:0] col_out;
   logic [3:0] row_in;
   logic       key_strobe;
   logic [3:0] key_code;
   logic [3:0] minute_out0;
   logic [3:0] minute_out1;
   logic [3:0] hour_out0;
   logic [1:0] hour_out1;
   logic [2:0] digit_count;
   logic       load_time;
   logic       load_alarm;
   logic       entry_err;

   logic       key_down;
   logic [1:0] press_row;
   logic [1:0] press_col;
   logic       act_lt;
   logic       act_la;
   logic       act_err;
   logic [13:0] buf_v;

   int checks;
   int errors;
   int strobe_cnt;
   int lt_cnt;
   int la_cnt;
   int err_cnt;
   int excl_viol;

   keypad_time_entry #(
      .SCAN_DIV     (4),
      .DEBOUNCE_CNT (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .col_out     (col_out),
      .row_in      (row_in),
      .key_strobe  (key_strobe),
      .key_code    (key_code),
      .minute_out0 (minute_out0),
      .minute_out1 (minute_out1),
      .hour_out0   (hour_out0),
      .hour_out1   (hour_out1),
      .digit_count (digit_count),
      .load_time   (load_time),
      .load_alarm  (load_alarm),
      .entry_err   (entry_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign buf_v = {hour_out1, hour_out0, minute_out1, minute_out0};

   // Pressed key shorts its row to the driven column.
   always_comb begin
      row_in = 4'hF;
      if (key_down && (col_out[press_col] == 1'b0)) begin
         row_in[press_row] = 1'b0;
      end
   end

   // Pulse counters and exclusivity watch.
   always @(negedge clk) begin
      if (key_strobe) strobe_cnt <= strobe_cnt + 1;
      if (load_time)  lt_cnt     <= lt_cnt + 1;
      if (load_alarm) la_cnt     <= la_cnt + 1;
      if (entry_err)  err_cnt    <= err_cnt + 1;
      if ((32'(load_time) + 32'(load_alarm) + 32'(entry_err)) > 32'd1) excl_viol <= excl_viol + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_key(input logic [3:0] code);
      case (code)
         4'h1: begin press_row = 2'd0; press_col = 2'd0; end
         4'h2: begin press_row = 2'd0; press_col = 2'd1; end
         4'h3: begin press_row = 2'd0; press_col = 2'd2; end
         4'hA: begin press_row = 2'd0; press_col = 2'd3; end
         4'h4: begin press_row = 2'd1; press_col = 2'd0; end
         4'h5: begin press_row = 2'd1; press_col = 2'd1; end
         4'h6: begin press_row = 2'd1; press_col = 2'd2; end
         4'hB: begin press_row = 2'd1; press_col = 2'd3; end
         4'h7: begin press_row = 2'd2; press_col = 2'd0; end
         4'h8: begin press_row = 2'd2; press_col = 2'd1; end
         4'h9: begin press_row = 2'd2; press_col = 2'd2; end
         4'hC: begin press_row = 2'd2; press_col = 2'd3; end
         4'hE: begin press_row = 2'd3; press_col = 2'd0; end
         4'h0: begin press_row = 2'd3; press_col = 2'd1; end
         4'hF: begin press_row = 2'd3; press_col = 2'd2; end
         default: begin press_row = 2'd3; press_col = 2'd3; end
      endcase
   endtask

   task automatic wait_strobe(input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (key_strobe) got = 1'b1;
      end
      check_eq({tag, "_strobe"}, 32'(got), 32'd1);
   endtask

   task automatic press_key(input logic [3:0] code, input string tag);
      set_key(code);
      key_down = 1'b1;
      wait_strobe(tag);
      check_eq({tag, "_code"}, 32'(key_code), 32'(code));
      @(negedge clk);
      act_lt  = load_time;
      act_la  = load_alarm;
      act_err = entry_err;
      key_down = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      int s0;
      int e0;
      bit moved;
      checks = 0; errors = 0;
      strobe_cnt = 0; lt_cnt = 0; la_cnt = 0; err_cnt = 0; excl_viol = 0;
      key_down = 1'b0; press_row = 2'd0; press_col = 2'd0;
      act_lt = 1'b0; act_la = 1'b0; act_err = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_col", 32'(col_out), 32'hE);
      check_eq("rst_count", 32'(digit_count), 32'd0);
      check_eq("rst_code", 32'(key_code), 32'd0);
      check_eq("rst_buf", 32'(buf_v), 32'h0);
      check_eq("rst_pulses", 32'({key_strobe, load_time, load_alarm, entry_err}), 32'd0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("rotate_first", 32'(col_out), 32'hD);

      // 12:34 then A commits to time
      press_key(4'h1, "d1");
      press_key(4'h2, "d2");
      press_key(4'h3, "d3");
      press_key(4'h4, "d4");
      check_eq("t_buf", 32'(buf_v), 32'h1234);
      check_eq("t_count4", 32'(digit_count), 32'd4);
      press_key(4'hA, "keyA");
      check_eq("t_load", 32'({act_lt, act_la, act_err}), 32'b100);
      check_eq("t_count0", 32'(digit_count), 32'd0);
      check_eq("t_retain", 32'(buf_v), 32'h1234);

      // position rules, full buffer, backspace, no-op keys
      press_key(4'hE, "star");
      check_eq("clr_buf", 32'(buf_v), 32'h0);
      press_key(4'h2, "h2");
      check_eq("h2_cnt", 32'(digit_count), 32'd1);
      press_key(4'h4, "h4");
      check_eq("h4_err", 32'(act_err), 32'd1);
      check_eq("h4_cnt", 32'(digit_count), 32'd1);
      check_eq("h4_buf", 32'(buf_v), 32'h2000);
      press_key(4'h3, "h3");
      press_key(4'h6, "m6");
      check_eq("m6_err", 32'(act_err), 32'd1);
      press_key(4'h5, "m5");
      press_key(4'h9, "m9");
      check_eq("full_buf", 32'(buf_v), 32'h2359);
      press_key(4'h1, "over");
      check_eq("over_err", 32'(act_err), 32'd1);
      check_eq("over_buf", 32'(buf_v), 32'h2359);
      press_key(4'hD, "bksp");
      check_eq("bksp", 32'({digit_count, buf_v}), {15'd0, 3'd3, 14'h2350});
      press_key(4'hC, "keyC");
      check_eq("keyC_nop", 32'({act_err, digit_count}), 32'd3);
      press_key(4'hF, "hash");
      check_eq("hash_nop", 32'({act_err, digit_count}), 32'd3);
      press_key(4'hA, "shortA");
      check_eq("shortA", 32'({act_lt, act_la, act_err}), 32'b001);
      press_key(4'hE, "star2");

      // one-slot glitch on key 5 must not strobe
      set_key(4'h5);
      s0 = strobe_cnt;
      for (int i = 0; i < 40 && col_out == 4'hD; i++) @(negedge clk);
      for (int i = 0; i < 40 && col_out != 4'hD; i++) @(negedge clk);
      check_eq("glitch_align", 32'(col_out), 32'hD);
      key_down = 1'b1;
      repeat (4) @(negedge clk);
      key_down = 1'b0;
      @(negedge clk);
      check_eq("glitch_frozen", 32'(col_out), 32'hD);
      moved = 1'b0;
      for (int i = 0; i < 20 && !moved; i++) begin
         @(negedge clk);
         if (col_out != 4'hD) moved = 1'b1;
      end
      check_eq("glitch_rescan", 32'(moved), 32'd1);
      repeat (10) @(negedge clk);
      check_eq("glitch_nostrobe", 32'(strobe_cnt - s0), 32'd0);

      // long hold of 5 with a single-slot release: one strobe only
      s0 = strobe_cnt;
      e0 = err_cnt;
      key_down = 1'b1;
      wait_strobe("hold");
      repeat (100) @(negedge clk);
      key_down = 1'b0;
      repeat (4) @(negedge clk);
      key_down = 1'b1;
      repeat (100) @(negedge clk);
      key_down = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("hold_one", 32'(strobe_cnt - s0), 32'd1);
      check_eq("hold_err", 32'(err_cnt - e0), 32'd1);
      press_key(4'h5, "repress");
      check_eq("repress_cnt", 32'(strobe_cnt - s0), 32'd2);

      // 09:30, backspace, 5, B commits to alarm
      press_key(4'h0, "a0");
      press_key(4'h9, "a9");
      press_key(4'h3, "a3");
      press_key(4'h0, "a0b");
      press_key(4'hD, "aD");
      check_eq("aD_cnt", 32'(digit_count), 32'd3);
      press_key(4'h5, "a5");
      press_key(4'hB, "keyB");
      check_eq("alarm_load", 32'({act_lt, act_la, act_err}), 32'b010);
      check_eq("alarm_buf", 32'(buf_v), 32'h0935);
      check_eq("alarm_cnt", 32'(digit_count), 32'd0);

      // reset while holding 7, then re-detect
      set_key(4'h7);
      key_down = 1'b1;
      wait_strobe("h7");
      repeat (6) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_col", 32'(col_out), 32'hE);
      check_eq("mid_rst_code", 32'(key_code), 32'd0);
      check_eq("mid_rst_buf", 32'({digit_count, buf_v}), 32'd0);
      check_eq("mid_rst_pulses", 32'({key_strobe, load_time, load_alarm, entry_err}), 32'd0);
      reset = 1'b1;
      wait_strobe("h7_again");
      check_eq("h7_again_code", 32'(key_code), 32'd7);
      key_down = 1'b0;
      repeat (20) @(negedge clk);

      check_eq("total_load_time", 32'(lt_cnt), 32'd1);
      check_eq("total_load_alarm", 32'(la_cnt), 32'd1);
      check_eq("pulse_exclusive", 32'(excl_viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
